multicycle_control_sequencer: RTL

- Parametrised multicycle control sequencer for the MIPS datapath.
- Owns the instruction register and the fetch/decode/execute state machine, and waits on memory through a req/ready handshake with a timeout.
- Decodes the opcode/funct groups into execute states and raises a sticky fault on an illegal opcode or a memory timeout.
- Sits between the memory interface and the datapath control-signal ROM; its state output drives the ROM address.

---
 rtl/multicycle_control_sequencer_pkg.sv | 88 ++++++++
 rtl/multicycle_control_sequencer_if.sv | 18 +
 rtl/multicycle_control_sequencer_instr_group_decode.sv | 53 +++++
 rtl/multicycle_control_sequencer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/multicycle_control_sequencer_pkg.sv
// Shared types and constants for the multicycle control sequencer: state numbers,
// opcode/funct encodings, fault codes and memory access sizes.
package mcs_pkg;

  // Values are the control-ROM addresses driven on the state output
  typedef enum logic [4:0] {
    S_IDLE       = 5'd0,
    S_FETCH_REQ  = 5'd1,
    S_FETCH_WAIT = 5'd2,
    S_IR_LOAD    = 5'd3,
    S_DECODE     = 5'd4,
    S_ADDU       = 5'd6,
    S_ST_REQ     = 5'd7,
    S_ST_WAIT    = 5'd8,
    S_BEQ        = 5'd11,
    S_BR_TAKE    = 5'd12,
    S_LD_REQ     = 5'd13,
    S_LD_WAIT    = 5'd14,
    S_LD_WB      = 5'd15,
    S_SUBU       = 5'd17,
    S_ADDIU      = 5'd18,
    S_SLTU       = 5'd19,
    S_SLTIU      = 5'd20,
    S_CLO        = 5'd21,
    S_CLZ        = 5'd22,
    S_AND        = 5'd23,
    S_ANDI       = 5'd24,
    S_OR         = 5'd25,
    S_ORI        = 5'd26,
    S_XOR        = 5'd27,
    S_XORI       = 5'd28,
    S_FAULT      = 5'd31
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_ILLEGAL  = 2'd1,
    FC_FETCH_TO = 2'd2,
    FC_DATA_TO  = 2'd3
  } fault_code_e;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_SLTIU    = 6'b001011;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_XORI     = 6'b001110;
  localparam logic [5:0] OP_LB       = 6'b100000;
  localparam logic [5:0] OP_LH       = 6'b100001;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_LBU      = 6'b100100;
  localparam logic [5:0] OP_LHU      = 6'b100101;
  localparam logic [5:0] OP_SB       = 6'b101000;
  localparam logic [5:0] OP_SH       = 6'b101001;
  localparam logic [5:0] OP_SW       = 6'b101011;

  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_CLO  = 6'b100001;
  localparam logic [5:0] F_CLZ  = 6'b100000;

  function automatic logic is_alu_state(input state_e s);
    return s inside {S_ADDU, S_SUBU, S_ADDIU, S_SLTU, S_SLTIU, S_CLO, S_CLZ,
                     S_AND, S_ANDI, S_OR, S_ORI, S_XOR, S_XORI};
  endfunction

  // Load/store opcodes carry the access size in their two low bits
  function automatic mem_size_e size_from_op(input logic [1:0] op_lo);
    case (op_lo)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_sequencer_if.sv
// Memory request/ready handshake between the sequencer (master) and memory (slave).
interface mcs_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_size,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_size,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/multicycle_control_sequencer_instr_group_decode.sv
// Combinational instruction-group decode: maps ir opcode/funct to the execute
// state, flagging any unsupported encoding as illegal.
module instr_group_decode
  import mcs_pkg::*;
(
  input  logic [31:0] ir,
  output state_e      next_state,
  output logic        illegal
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_ir_bits;

  assign op             = ir[31:26];
  assign funct          = ir[5:0];
  assign unused_ir_bits = ^ir[25:6];

  always_comb begin
    next_state = S_FAULT;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_ADDU:  next_state = S_ADDU;
          F_SUBU:  next_state = S_SUBU;
          F_SLTU:  next_state = S_SLTU;
          F_AND:   next_state = S_AND;
          F_OR:    next_state = S_OR;
          F_XOR:   next_state = S_XOR;
          default: next_state = S_FAULT;
        endcase
      end
      OP_SPECIAL2: begin
        case (funct)
          F_CLO:   next_state = S_CLO;
          F_CLZ:   next_state = S_CLZ;
          default: next_state = S_FAULT;
        endcase
      end
      OP_ADDIU:                          next_state = S_ADDIU;
      OP_SLTIU:                          next_state = S_SLTIU;
      OP_ANDI:                           next_state = S_ANDI;
      OP_ORI:                            next_state = S_ORI;
      OP_XORI:                           next_state = S_XORI;
      OP_SB, OP_SH, OP_SW:               next_state = S_ST_REQ;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: next_state = S_LD_REQ;
      OP_BEQ:                            next_state = S_BEQ;
      default:                           next_state = S_FAULT;
    endcase
    illegal = (next_state == S_FAULT);
  end

endmodule

// File: rtl/multicycle_control_sequencer.sv
// Multicycle fetch/decode/execute sequencer: owns ir, drives the control-ROM state
// number, and handshakes with memory under a bounded wait.
module multicycle_control_sequencer
  import mcs_pkg::*;
#(
  parameter int unsigned STATE_W = 7,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  mcs_mem_if.master          mem,
  input  logic               branch_cond,
  output logic [STATE_W-1:0] state,
  output logic [31:0]        ir,
  output logic               ir_ld,
  output logic               pc_inc,
  output logic               pc_br,
  output logic               reg_we,
  output logic               fault,
  output logic [1:0]         fault_code
);

  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e          cur;
  logic [TO_W-1:0] to_cnt;
  state_e          dec_state;
  logic            dec_illegal;
  logic            in_wait;
  logic            wait_expired;
  mem_size_e       size_sel;

  instr_group_decode u_decode (
    .ir         (ir),
    .next_state (dec_state),
    .illegal    (dec_illegal)
  );

  assign in_wait = cur inside {S_FETCH_WAIT, S_ST_WAIT, S_LD_WAIT};
  // The counter holds completed wait cycles, so the current one is the
  // TIMEOUT-th when it reads TIMEOUT-1; ready is tested first and wins.
  assign wait_expired = (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= S_IDLE;
      ir         <= '0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      to_cnt     <= '0;
    end else if (run) begin
      case (cur)
        S_IDLE:      cur <= S_FETCH_REQ;
        S_FETCH_REQ: begin
          cur    <= S_FETCH_WAIT;
          to_cnt <= '0;
        end
        S_FETCH_WAIT: begin
          if (mem.mem_ready) begin
            cur <= S_IR_LOAD;
          end else if (wait_expired) begin
            cur        <= S_FAULT;
            fault      <= 1'b1;
            fault_code <= FC_FETCH_TO;
          end
        end
        S_IR_LOAD: begin
          ir  <= mem.mem_rdata;
          cur <= S_DECODE;
        end
        S_DECODE: begin
          cur <= dec_state;
          if (dec_illegal) begin
            fault      <= 1'b1;
            fault_code <= FC_ILLEGAL;
          end
        end
        S_ST_REQ: begin
          cur    <= S_ST_WAIT;
          to_cnt <= '0;
        end
        S_ST_WAIT: begin
          if (mem.mem_ready) begin
            cur <= S_FETCH_REQ;
          end else if (wait_expired) begin
            cur        <= S_FAULT;
            fault      <= 1'b1;
            fault_code <= FC_DATA_TO;
          end
        end
        S_LD_REQ: begin
          cur    <= S_LD_WAIT;
          to_cnt <= '0;
        end
        S_LD_WAIT: begin
          if (mem.mem_ready) begin
            cur <= S_LD_WB;
          end else if (wait_expired) begin
            cur        <= S_FAULT;
            fault      <= 1'b1;
            fault_code <= FC_DATA_TO;
          end
        end
        S_LD_WB:   cur <= S_FETCH_REQ;
        S_BEQ:     cur <= branch_cond ? S_BR_TAKE : S_FETCH_REQ;
        S_BR_TAKE: cur <= S_FETCH_REQ;
        S_ADDU, S_SUBU, S_ADDIU, S_SLTU, S_SLTIU, S_CLO, S_CLZ,
        S_AND, S_ANDI, S_OR, S_ORI, S_XOR, S_XORI:
                   cur <= S_FETCH_REQ;
        default:   cur <= S_FAULT;
      endcase
      if (in_wait && (to_cnt != TO_MAX)) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  always_comb begin
    size_sel = SZ_BYTE;
    if (cur inside {S_FETCH_REQ, S_FETCH_WAIT}) begin
      size_sel = SZ_WORD;
    end else if (cur inside {S_ST_REQ, S_ST_WAIT, S_LD_REQ, S_LD_WAIT}) begin
      size_sel = size_from_op(ir[27:26]);
    end
  end

  // Strobes follow state directly and are all gated by run, so a stall drops
  // the request and it reissues when run returns.
  assign mem.mem_req  = run && (cur inside {S_FETCH_REQ, S_FETCH_WAIT, S_ST_REQ,
                                            S_ST_WAIT, S_LD_REQ, S_LD_WAIT});
  assign mem.mem_we   = run && (cur inside {S_ST_REQ, S_ST_WAIT});
  assign mem.mem_size = size_sel;
  assign ir_ld        = run && (cur == S_IR_LOAD);
  assign pc_inc       = run && (cur == S_IR_LOAD);
  assign pc_br        = run && (cur == S_BR_TAKE);
  assign reg_we       = run && (is_alu_state(cur) || (cur == S_LD_WB));
  assign state        = STATE_W'(cur);

endmodule
